// File: rtl/cache_port_arbiter.sv
// Two-requester round-robin arbiter for the core_top cache port.
// Reads are tagged in a requester-ID FIFO so in-order responses route back to their owner.
module cache_port_arbiter #(
  parameter int unsigned ADDR_W    = 21,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_data,
  input  logic              m0_req_wr,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_data,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_data,
  input  logic              m1_req_wr,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_data,
  output logic              cache_req_valid,
  input  logic              cache_req_ready,
  output logic [ADDR_W-1:0] cache_req_addr,
  output logic [DATA_W-1:0] cache_req_data,
  output logic              cache_req_wr,
  input  logic              cache_rsp_valid,
  input  logic [DATA_W-1:0] cache_rsp_data,
  output logic              rsp_err
);

  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]           state;
  logic [0:0]           state_next;
  logic                 rr_ptr;
  logic                 issue_id;
  logic [CNT_W-1:0]     cnt;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [TAG_DEPTH-1:0] id_mem;
  logic                 tags_free;
  logic                 elig0;
  logic                 elig1;
  logic                 grant0;
  logic                 grant1;
  logic                 push;
  logic                 pop;
  logic                 head_id;

  // Next-state, grant and FIFO control; rr_ptr=1 favours M1 on a tie
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    push       = 1'b0;
    tags_free  = (cnt < CNT_W'(TAG_DEPTH));
    elig0      = m0_req_valid && (!m0_req_wr || tags_free);
    elig1      = m1_req_valid && (!m1_req_wr || tags_free);
    pop        = cache_rsp_valid && (cnt != '0);
    head_id    = id_mem[rd_ptr];
    case (state)
      IDLE: begin
        if (elig0 && (!elig1 || !rr_ptr)) begin
          grant0     = 1'b1;
          state_next = ISSUE;
        end else if (elig1) begin
          grant1     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (cache_req_ready) begin
          state_next = IDLE;
          push       = cache_req_wr;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign m0_req_ready = grant0;
  assign m1_req_ready = grant1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Request stage: latch the winner's payload and hold it until the cache accepts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cache_req_valid <= 1'b0;
      cache_req_addr  <= '0;
      cache_req_data  <= '0;
      cache_req_wr    <= 1'b0;
      issue_id        <= 1'b0;
      rr_ptr          <= 1'b0;
    end else if (grant0 || grant1) begin
      cache_req_valid <= 1'b1;
      cache_req_addr  <= grant1 ? m1_req_addr : m0_req_addr;
      cache_req_data  <= grant1 ? m1_req_data : m0_req_data;
      cache_req_wr    <= grant1 ? m1_req_wr   : m0_req_wr;
      issue_id        <= grant1;
      rr_ptr          <= !grant1;
    end else if (state == ISSUE && cache_req_ready) begin
      cache_req_valid <= 1'b0;
    end
  end

  // Requester-ID FIFO of outstanding reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= issue_id;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Response routing, one cycle after the cache response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_rsp_valid <= 1'b0;
      m0_rsp_data  <= '0;
      m1_rsp_valid <= 1'b0;
      m1_rsp_data  <= '0;
      rsp_err      <= 1'b0;
    end else begin
      m0_rsp_valid <= pop && !head_id;
      m1_rsp_valid <= pop && head_id;
      if (pop && !head_id) m0_rsp_data <= cache_rsp_data;
      if (pop && head_id)  m1_rsp_data <= cache_rsp_data;
      if (cache_rsp_valid && cnt == '0) rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: arbitration, tag-FIFO routing, error flag and reset.
module tb_cache_port_arbiter;

  localparam int unsigned AW = 21;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          reset;
  logic          m0_req_valid, m0_req_ready, m0_req_wr, m0_rsp_valid;
  logic [AW-1:0] m0_req_addr;
  logic [DW-1:0] m0_req_data, m0_rsp_data;
  logic          m1_req_valid, m1_req_ready, m1_req_wr, m1_rsp_valid;
  logic [AW-1:0] m1_req_addr;
  logic [DW-1:0] m1_req_data, m1_rsp_data;
  logic          cache_req_valid, cache_req_ready, cache_req_wr;
  logic [AW-1:0] cache_req_addr;
  logic [DW-1:0] cache_req_data;
  logic          cache_rsp_valid;
  logic [DW-1:0] cache_rsp_data;
  logic          rsp_err;

  int total = 0;
  int bad   = 0;

  cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
    .m0_req_data(m0_req_data), .m0_req_wr(m0_req_wr), .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_data(m0_rsp_data),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
    .m1_req_data(m1_req_data), .m1_req_wr(m1_req_wr), .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_data(m1_rsp_data),
    .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
    .cache_req_addr(cache_req_addr), .cache_req_data(cache_req_data), .cache_req_wr(cache_req_wr),
    .cache_rsp_valid(cache_rsp_valid), .cache_rsp_data(cache_rsp_data), .rsp_err(rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single read from one requester with the cache ready; checks grant and issued address
  task automatic issue_read(input logic who, input logic [AW-1:0] addr, input string tag);
    if (who) begin m1_req_valid = 1'b1; m1_req_wr = 1'b1; m1_req_addr = addr; end
    else     begin m0_req_valid = 1'b1; m0_req_wr = 1'b1; m0_req_addr = addr; end
    #1;
    chk({tag, "_ready"}, 32'(who ? m1_req_ready : m0_req_ready), 32'd1);
    step();
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    chk({tag, "_addr"}, 32'(cache_req_addr), 32'(addr));
    step();
  endtask

  task automatic rsp_pulse(input logic [DW-1:0] data);
    cache_rsp_valid = 1'b1;
    cache_rsp_data  = data;
    step();
    cache_rsp_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    m0_req_valid = 1'b0; m0_req_addr = '0; m0_req_data = '0; m0_req_wr = 1'b0;
    m1_req_valid = 1'b0; m1_req_addr = '0; m1_req_data = '0; m1_req_wr = 1'b0;
    cache_req_ready = 1'b0; cache_rsp_valid = 1'b0; cache_rsp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(cache_req_valid), 32'd0);
    chk("rst_req_addr",  32'(cache_req_addr),  32'd0);
    chk("rst_req_wr",    32'(cache_req_wr),    32'd0);
    chk("rst_m0_ready",  32'(m0_req_ready),    32'd0);
    chk("rst_m1_ready",  32'(m1_req_ready),    32'd0);
    chk("rst_m0_rspv",   32'(m0_rsp_valid),    32'd0);
    chk("rst_err",       32'(rsp_err),         32'd0);
    reset = 1'b1;
    step();

    // Both requesters hold writes: pointer starts at M0, so grants go M0,M1,M0,M1
    m0_req_valid = 1'b1; m0_req_wr = 1'b0; m0_req_addr = 21'h00100; m0_req_data = 32'h000000A0;
    m1_req_valid = 1'b1; m1_req_wr = 1'b0; m1_req_addr = 21'h00200; m1_req_data = 32'h000000B0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_m0_ready", 32'(m0_req_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_m1_ready", 32'(m1_req_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      step();
      chk("rr_valid", 32'(cache_req_valid), 32'd1);
      chk("rr_addr",  32'(cache_req_addr), (k % 2 == 0) ? 32'h00100 : 32'h00200);
      step();
      chk("rr_hold_addr", 32'(cache_req_addr), (k % 2 == 0) ? 32'h00100 : 32'h00200);
      chk("rr_hold_data", cache_req_data, (k % 2 == 0) ? 32'hA0 : 32'hB0);
      chk("rr_hold_wr",   32'(cache_req_wr), 32'd0);
      chk("rr_no_ready",  32'(m0_req_ready | m1_req_ready), 32'd0);
      cache_req_ready = 1'b1;
      step();
      cache_req_ready = 1'b0;
      #1;
    end
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    chk("rr_done_valid", 32'(cache_req_valid), 32'd0);

    // Lone M0 read, response 3 cycles after issue
    cache_req_ready = 1'b1;
    issue_read(1'b0, 21'h00010, "rd1");
    chk("rd1_wr", 32'(cache_req_wr), 32'd1);
    step();
    step();
    rsp_pulse(32'hDEADBEEF);
    chk("rd1_m0_rspv", 32'(m0_rsp_valid), 32'd1);
    chk("rd1_m0_data", m0_rsp_data, 32'hDEADBEEF);
    chk("rd1_m1_rspv", 32'(m1_rsp_valid), 32'd0);
    step();
    chk("rd1_pulse_end", 32'(m0_rsp_valid), 32'd0);
    chk("rd1_data_held", m0_rsp_data, 32'hDEADBEEF);

    // Four M1 reads fill the tag FIFO
    for (int k = 0; k < 4; k++) issue_read(1'b1, AW'(21'h00400 + k), "fill");
    m0_req_valid = 1'b1; m0_req_wr = 1'b1; m0_req_addr = 21'h00300;
    #1;
    chk("full_rd_blocked", 32'(m0_req_ready), 32'd0);
    step();
    chk("full_rd_blocked2", 32'(m0_req_ready), 32'd0);
    chk("full_no_req", 32'(cache_req_valid), 32'd0);
    m0_req_wr = 1'b0; m0_req_addr = 21'h00301;
    #1;
    chk("full_wr_ready", 32'(m0_req_ready), 32'd1);
    step();
    m0_req_wr = 1'b1; m0_req_addr = 21'h00300;
    chk("full_wr_addr", 32'(cache_req_addr), 32'h00301);
    chk("full_wr_wr", 32'(cache_req_wr), 32'd0);
    step();
    chk("full_rd_still", 32'(m0_req_ready), 32'd0);
    rsp_pulse(32'h00000011);
    chk("pop1_m1_rspv", 32'(m1_rsp_valid), 32'd1);
    chk("pop1_m1_data", m1_rsp_data, 32'h00000011);
    chk("pop1_m0_rspv", 32'(m0_rsp_valid), 32'd0);
    chk("pop1_m0_ready", 32'(m0_req_ready), 32'd1);
    step();
    m0_req_valid = 1'b0;
    chk("pop1_m0_addr", 32'(cache_req_addr), 32'h00300);
    step();
    rsp_pulse(32'h00000022);
    chk("drain1", m1_rsp_data, 32'h00000022);
    rsp_pulse(32'h00000033);
    chk("drain2", m1_rsp_data, 32'h00000033);
    rsp_pulse(32'h00000044);
    chk("drain3", m1_rsp_data, 32'h00000044);
    chk("drain3_v", 32'(m1_rsp_valid), 32'd1);
    rsp_pulse(32'h00000055);
    chk("drain4_m0v", 32'(m0_rsp_valid), 32'd1);
    chk("drain4_m0d", m0_rsp_data, 32'h00000055);
    chk("drain4_m1v", 32'(m1_rsp_valid), 32'd0);
    chk("drain_err", 32'(rsp_err), 32'd0);

    // Interleaved reads M0,M1,M0 with responses A,B,C back to back
    issue_read(1'b0, 21'h00501, "il0");
    issue_read(1'b1, 21'h00502, "il1");
    issue_read(1'b0, 21'h00503, "il2");
    rsp_pulse(32'hAAAA0001);
    chk("il_a_v", 32'({m1_rsp_valid, m0_rsp_valid}), 32'b01);
    chk("il_a_d", m0_rsp_data, 32'hAAAA0001);
    rsp_pulse(32'hBBBB0002);
    chk("il_b_v", 32'({m1_rsp_valid, m0_rsp_valid}), 32'b10);
    chk("il_b_d", m1_rsp_data, 32'hBBBB0002);
    rsp_pulse(32'hCCCC0003);
    chk("il_c_v", 32'({m1_rsp_valid, m0_rsp_valid}), 32'b01);
    chk("il_c_d", m0_rsp_data, 32'hCCCC0003);

    // Stray response with nothing outstanding
    rsp_pulse(32'h12345678);
    chk("stray_v", 32'({m1_rsp_valid, m0_rsp_valid}), 32'b00);
    chk("stray_err", 32'(rsp_err), 32'd1);
    chk("stray_m0_data", m0_rsp_data, 32'hCCCC0003);
    step();
    step();
    chk("stray_err_held", 32'(rsp_err), 32'd1);

    // Reset during ISSUE with two reads outstanding
    issue_read(1'b0, 21'h00601, "pre0");
    issue_read(1'b1, 21'h00602, "pre1");
    cache_req_ready = 1'b0;
    m0_req_valid = 1'b1; m0_req_wr = 1'b1; m0_req_addr = 21'h00603;
    step();
    m0_req_valid = 1'b0;
    chk("mid_valid", 32'(cache_req_valid), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("ar_valid", 32'(cache_req_valid), 32'd0);
    chk("ar_addr",  32'(cache_req_addr),  32'd0);
    chk("ar_err",   32'(rsp_err),         32'd0);
    chk("ar_m0d",   m0_rsp_data,          32'd0);
    step();
    reset = 1'b1;
    cache_req_ready = 1'b1;
    step();
    chk("post_valid", 32'(cache_req_valid), 32'd0);
    rsp_pulse(32'h0BAD0BAD);
    chk("post_rspv", 32'({m1_rsp_valid, m0_rsp_valid}), 32'b00);
    chk("post_err", 32'(rsp_err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
